// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv
// Purpose  : Iterative multiply/divide unit with architectural HI/LO.
//            MULT/MULTU use one shift-add step per cycle, and DIV/DIVU use
//            one restoring-division step per cycle. MTHI/MTLO/MFHI/MFLO
//            complete in a single cycle.
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             stallreq,
    output logic             busy,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    // Multiply: {partial product high, multiplier shifting out}.
    // Divide:   {remainder, dividend shifting out / quotient shifting in}.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_q;    // product / quotient must be negated
    logic               r_neg_r;    // remainder must be negated
    logic               r_is_div;
    logic               r_dz;       // current operation is a divide by zero

    // Launch decode
    logic               w_launch;
    logic               w_signed;
    logic               w_neg1;
    logic               w_neg2;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic               w_zero_div;
    logic               w_last;

    assign w_launch   = (r_state == S_IDLE) && op_valid && !op[2] && !flush;
    assign w_signed   = !op[0];
    assign w_neg1     = w_signed && src1[WIDTH-1];
    assign w_neg2     = w_signed && src2[WIDTH-1];
    assign w_abs1     = w_neg1 ? -src1 : src1;
    assign w_abs2     = w_neg2 ? -src2 : src2;
    assign w_zero_div = op[1] && (src2 == '0);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    // Shift-add step: add multiplicand to the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_addend   = r_acc[0] ? {1'b0, r_opb} : '0;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: shift the next dividend bit into the remainder and
    // keep the difference only when it does not borrow.
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_ok    = !w_div_diff[WIDTH];
    assign w_div_next  = {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ok};

    // Sign correction applied at writeback
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quot_fix = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and handshake outputs; flush and reset dominate
    always_comb begin
        w_next   = r_state;
        stallreq = 1'b0;
        busy     = (r_state != S_IDLE);
        div_zero = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    stallreq = 1'b1;
                    if (w_zero_div) begin
                        w_next = S_DONE;
                    end else if (op[1]) begin
                        w_next = S_DIV;
                    end else begin
                        w_next = S_MUL;
                    end
                end
            end
            S_MUL: begin
                stallreq = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DIV: begin
                stallreq = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next   = S_IDLE;
                div_zero = r_dz;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (flush) begin
            w_next   = S_IDLE;
            stallreq = 1'b0;
        end
        if (!rst) begin
            stallreq = 1'b0;
        end
    end

    // Operand capture at launch and one iteration step per busy cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc    <= '0;
            r_opb    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
        end else if (w_launch) begin
            r_cnt    <= '0;
            r_is_div <= op[1];
            r_dz     <= w_zero_div;
            if (w_zero_div) begin
                // Pending result is raw src1 / all-ones with no correction
                r_acc   <= {src1, {WIDTH{1'b1}}};
                r_opb   <= '0;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
            end else if (op[1]) begin
                r_acc   <= {{WIDTH{1'b0}}, w_abs1};
                r_opb   <= w_abs2;
                r_neg_q <= w_neg1 ^ w_neg2;
                r_neg_r <= w_neg1;
            end else begin
                r_acc   <= {{WIDTH{1'b0}}, w_abs2};
                r_opb   <= w_abs1;
                r_neg_q <= w_neg1 ^ w_neg2;
                r_neg_r <= 1'b0;
            end
        end else if (r_state == S_MUL) begin
            r_acc <= w_mul_next;
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (r_state == S_DIV) begin
            r_acc <= w_div_next;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Architectural HI/LO: writeback on DONE, moves from GPRs in IDLE
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (!flush) begin
            if (r_state == S_DONE) begin
                if (r_is_div) begin
                    r_hi <= w_rem_fix;
                    r_lo <= w_quot_fix;
                end else begin
                    r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                    r_lo <= w_prod_fix[WIDTH-1:0];
                end
            end else if (r_state == S_IDLE && op_valid) begin
                if (op == 3'd4) begin
                    r_hi <= src1;
                end else if (op == 3'd5) begin
                    r_lo <= src1;
                end
            end
        end
    end

    // MFHI/MFLO read port
    always_comb begin
        result_o = '0;
        if (op_valid && op == 3'd6) begin
            result_o = r_hi;
        end else if (op_valid && op == 3'd7) begin
            result_o = r_lo;
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv
// Purpose  : Self-checking bench for alu_muldiv: table of mul/div vectors
//            with a HI/LO scoreboard, plus hand-written sequences for
//            move/flush/reset corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         op_valid;
    logic [2:0]   op;
    logic [W-1:0] src1;
    logic [W-1:0] src2;
    logic         flush;
    logic         stallreq;
    logic         busy;
    logic [W-1:0] result_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;
    logic         div_zero;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .flush    (flush),
        .stallreq (stallreq),
        .busy     (busy),
        .result_o (result_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           stalls;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    localparam int NV = 13;
    vec_t vecs[NV];
    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;

    function automatic vec_t mk(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz,
                                input int stalls);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dz = dz; v.stalls = stalls;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to 2 time units past the next rising edge (input drive point)
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Launch one mul/div op, count stall cycles, then check writeback
    task automatic run_vec(input vec_t v, input int idx);
        int   stalls;
        exp_t e;
        op_valid = 1'b1;
        op       = v.op;
        src1     = v.a;
        src2     = v.b;
        e.hi     = v.hi;
        e.lo     = v.lo;
        sb_q.push_back(e);
        #1;
        stalls = 0;
        while (stallreq === 1'b1 && stalls < 100) begin
            stalls++;
            @(posedge clk);
            #3;
            // Operands must already be captured
            src1 = ~v.a;
            src2 = ~v.b;
        end
        chk($sformatf("v%0d_stall_cycles", idx), 64'(stalls), 64'(v.stalls));
        chk($sformatf("v%0d_busy_done", idx), 64'(busy), 64'd1);
        chk($sformatf("v%0d_div_zero_done", idx), 64'(div_zero), 64'(v.dz));
        chk($sformatf("v%0d_result_o", idx), 64'(result_o), 64'd0);
        @(posedge clk);
        #2;
        op_valid = 1'b0;
        #1;
        e = sb_q.pop_front();
        chk($sformatf("v%0d_hi", idx), 64'(hi_o), 64'(e.hi));
        chk($sformatf("v%0d_lo", idx), 64'(lo_o), 64'(e.lo));
        chk($sformatf("v%0d_no_relaunch", idx), 64'(busy), 64'd0);
        chk($sformatf("v%0d_div_zero_after", idx), 64'(div_zero), 64'd0);
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 33);
        vecs[1]  = mk(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
        vecs[2]  = mk(3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
        vecs[3]  = mk(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33);
        vecs[4]  = mk(3'd3, 32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 1'b1, 1);
        vecs[5]  = mk(3'd0, 32'd7,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, 1'b0, 33);
        vecs[6]  = mk(3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 33);
        vecs[7]  = mk(3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33);
        vecs[8]  = mk(3'd1, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 1'b0, 33);
        vecs[9]  = mk(3'd2, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 1);
        vecs[10] = mk(3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33);
        vecs[11] = mk(3'd3, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, 33);
        vecs[12] = mk(3'd2, 32'hFFFFFFF7, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h00000002, 1'b0, 33);

        // Reset: stallreq must stay low even with a launchable op presented
        rst = 1'b0; flush = 1'b0; op_valid = 1'b1; op = 3'd0; src1 = 32'd5; src2 = 32'd5;
        next_cycle();
        next_cycle();
        #1;
        chk("rst_stallreq", 64'(stallreq), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi_o), 64'd0);
        chk("rst_lo", 64'(lo_o), 64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);
        next_cycle();
        rst = 1'b1;
        op_valid = 1'b0;
        next_cycle();

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
        end

        // MTHI then MFHI; MTLO then MFLO; never stalls
        op_valid = 1'b1; op = 3'd4; src1 = 32'h1234;
        #1;
        chk("mthi_stallreq", 64'(stallreq), 64'd0);
        next_cycle();
        op = 3'd6; src1 = 32'h0;
        #1;
        chk("mfhi_result", 64'(result_o), 64'h1234);
        chk("mfhi_stallreq", 64'(stallreq), 64'd0);
        chk("mthi_lo_kept", 64'(lo_o), 64'(vecs[NV-1].lo));
        next_cycle();
        op = 3'd5; src1 = 32'hABCD;
        #1;
        chk("mtlo_stallreq", 64'(stallreq), 64'd0);
        next_cycle();
        op = 3'd7; src1 = 32'h0;
        #1;
        chk("mflo_result", 64'(result_o), 64'hABCD);
        chk("mtlo_hi_kept", 64'(hi_o), 64'h1234);
        next_cycle();
        op_valid = 1'b0;
        next_cycle();

        // Flush in the 10th MUL cycle
        op_valid = 1'b1; op = 3'd0; src1 = 32'd3; src2 = 32'd5;
        for (int i = 1; i <= 10; i++) begin
            next_cycle();
        end
        flush = 1'b1;
        #1;
        chk("flush_stallreq", 64'(stallreq), 64'd0);
        next_cycle();
        flush = 1'b0; op_valid = 1'b0;
        #1;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_stall_after", 64'(stallreq), 64'd0);
        repeat (40) next_cycle();
        #1;
        chk("flush_hi_kept", 64'(hi_o), 64'h1234);
        chk("flush_lo_kept", 64'(lo_o), 64'hABCD);
        next_cycle();

        // Reset in the 5th DIV cycle
        op_valid = 1'b1; op = 3'd2; src1 = 32'd100; src2 = 32'd3;
        for (int i = 1; i <= 5; i++) begin
            next_cycle();
        end
        rst = 1'b0;
        #1;
        chk("midrst_stallreq", 64'(stallreq), 64'd0);
        next_cycle();
        rst = 1'b1; op_valid = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_stallreq", 64'(stallreq), 64'd0);
        chk("midrst_hi", 64'(hi_o), 64'd0);
        chk("midrst_lo", 64'(lo_o), 64'd0);
        next_cycle();

        // Flush during DONE suppresses the writeback
        op_valid = 1'b1; op = 3'd3; src1 = 32'd7; src2 = 32'd0;
        next_cycle();
        flush = 1'b1; op_valid = 1'b0;
        next_cycle();
        flush = 1'b0;
        #1;
        chk("flushdone_hi", 64'(hi_o), 64'd0);
        chk("flushdone_lo", 64'(lo_o), 64'd0);
        chk("flushdone_busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
